// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the LC-3b control FSM handshake.
// Accepts a request on MIO_EN and waits a fixed LATENCY. It then performs the
// read or write on an internal 16-bit word array and pulses R for one cycle.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   MIO_EN     access request, held by the FSM until R is seen
//   R_W        0 = read, 1 = write (sampled at acceptance)
//   DATA_SIZE  0 = byte, 1 = word (sampled at acceptance)
//   MAR        byte address (sampled at acceptance)
//   MDR_in     write data (sampled at acceptance)
//   R          one-cycle completion pulse
//   MDR_out    read data, held until the next read completes
//   busy       high in BUSY and READY
module mem_responder #(
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned LATENCY = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MIO_EN,
   input  logic        R_W,
   input  logic        DATA_SIZE,
   input  logic [15:0] MAR,
   input  logic [15:0] MDR_in,
   output logic        R,
   output logic [15:0] MDR_out,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, BUSY, READY, DRAIN} state_e;

   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   state_e            state_q;
   logic [3:0]        cnt_q;
   logic              rw_q;
   logic              size_q;
   logic [ADDR_W:0]   mar_q;
   logic [15:0]       wdata_q;
   logic              r_q;
   logic              busy_q;
   logic [15:0]       rdata_q;

   logic [15:0]       mem_q [(1 << ADDR_W)];

   logic [ADDR_W-1:0] idx_d;
   logic              complete_d;
   logic              we_lo_d;
   logic              we_hi_d;
   logic [7:0]        wlo_d;
   logic [7:0]        whi_d;

   // Upper address bits alias away by design.
   logic              unused_mar;
   assign unused_mar = ^MAR[15:ADDR_W+1];

   // Byte writes always carry data in MDR_in[7:0]; a high-lane byte write
   // therefore routes the low byte onto bits 15:8.
   always_comb begin
      idx_d      = mar_q[ADDR_W:1];
      complete_d = (state_q == BUSY) && (cnt_q == 4'd0);
      we_lo_d    = complete_d && rw_q && (size_q || !mar_q[0]);
      we_hi_d    = complete_d && rw_q && (size_q ||  mar_q[0]);
      wlo_d      = wdata_q[7:0];
      whi_d      = size_q ? wdata_q[15:8] : wdata_q[7:0];
   end

   // Storage is not reset; lanes are written independently.
   always_ff @(posedge clk) begin
      if (we_lo_d) mem_q[idx_d][7:0]  <= wlo_d;
      if (we_hi_d) mem_q[idx_d][15:8] <= whi_d;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rw_q    <= 1'b0;
         size_q  <= 1'b0;
         mar_q   <= '0;
         wdata_q <= '0;
         r_q     <= 1'b0;
         busy_q  <= 1'b0;
         rdata_q <= '0;
      end else begin
         r_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (MIO_EN) begin
                  rw_q    <= R_W;
                  size_q  <= DATA_SIZE;
                  mar_q   <= MAR[ADDR_W:0];
                  wdata_q <= MDR_in;
                  cnt_q   <= CNT_LOAD;
                  busy_q  <= 1'b1;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               if (cnt_q != 4'd0) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  if (!rw_q) rdata_q <= mem_q[idx_d];
                  r_q     <= 1'b1;
                  state_q <= READY;
               end
            end
            READY: begin
               busy_q  <= 1'b0;
               state_q <= DRAIN;
            end
            DRAIN: begin
               // Wait for the request to drop so a held MIO_EN is served once.
               if (!MIO_EN) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign R       = r_q;
   assign MDR_out = rdata_q;
   assign busy    = busy_q;

endmodule
